// File: rtl/matrix_preset_scanner_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_preset_scanner_if                                                 |
// | Control, pattern-write and matrix-drive signals of the preset scanner.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface matrix_preset_scanner_if #(
   parameter int COLS  = 5,
   parameter int ROWS  = 7,
   parameter int SEL_W = 2
);
   localparam int c_ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic               en;
   logic [SEL_W-1:0]   sel_in;
   logic               blink_en;
   logic               wr_en;
   logic [SEL_W-1:0]   wr_sel;
   logic [c_ROW_W-1:0] wr_row;
   logic [COLS-1:0]    wr_data;
   logic [ROWS-1:0]    row_oh;
   logic [COLS-1:0]    col_out;
   logic               frame_done;

   modport master (
      output en, sel_in, blink_en, wr_en, wr_sel, wr_row, wr_data,
      input  row_oh, col_out, frame_done
   );

   modport slave (
      input  en, sel_in, blink_en, wr_en, wr_sel, wr_row, wr_data,
      output row_oh, col_out, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/matrix_preset_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_preset_scanner                                                    |
// | Row scanner for NPAT writable LED-matrix presets, with blink and enable. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module matrix_preset_scanner #(
   parameter int COLS         = 5,
   parameter int ROWS         = 7,
   parameter int SEL_W        = 2,
   parameter int DIV          = 4,
   parameter int BLINK_FRAMES = 2
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   matrix_preset_scanner_if.slave bus
);
   localparam int c_NPAT  = 2 ** SEL_W;
   localparam int c_ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int c_PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int c_BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [COLS-1:0]    r_mem [c_NPAT][ROWS];
   logic [c_PRE_W-1:0] r_presc;
   logic [c_ROW_W-1:0] r_row_idx;
   logic [SEL_W-1:0]   r_sel_active;
   logic [c_BLK_W-1:0] r_blink_cnt;
   logic               r_blank;
   logic [ROWS-1:0]    r_row_oh;
   logic [COLS-1:0]    r_col_out;
   logic               r_frame_done;

   logic w_tick;
   logic w_last_row;
   logic w_wrap;
   logic w_blink_last;
   logic w_show;
   logic w_wr_ok;

   assign w_tick       = bus.en && (r_presc == c_PRE_W'(DIV - 1));
   assign w_last_row   = (r_row_idx == c_ROW_W'(ROWS - 1));
   assign w_wrap       = w_tick && w_last_row;
   assign w_blink_last = (r_blink_cnt == c_BLK_W'(BLINK_FRAMES - 1));
   assign w_show       = bus.en && !r_blank;
   assign w_wr_ok      = (int'(bus.wr_row) < ROWS);

   // Pattern store; writes are independent of scan state and enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < c_NPAT; p++) begin
            for (int r = 0; r < ROWS; r++) begin
               r_mem[p][r] <= '0;
            end
         end
      end else if (bus.wr_en && w_wr_ok) begin
         r_mem[bus.wr_sel][bus.wr_row] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc      <= '0;
         r_row_idx    <= '0;
         r_sel_active <= '0;
         r_blink_cnt  <= '0;
         r_blank      <= 1'b0;
         r_row_oh     <= '0;
         r_col_out    <= '0;
         r_frame_done <= 1'b0;
      end else begin
         if (w_tick) begin
            r_presc   <= '0;
            r_row_idx <= w_last_row ? '0 : r_row_idx + c_ROW_W'(1);
         end else if (bus.en) begin
            r_presc <= r_presc + c_PRE_W'(1);
         end

         r_frame_done <= w_wrap;

         // Pattern switches only at the frame boundary so a frame never tears.
         if (w_wrap) begin
            r_sel_active <= bus.sel_in;
         end

         if (!bus.blink_en) begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
         end else if (w_wrap) begin
            if (w_blink_last) begin
               r_blink_cnt <= '0;
               r_blank     <= ~r_blank;
            end else begin
               r_blink_cnt <= r_blink_cnt + c_BLK_W'(1);
            end
         end

         r_row_oh  <= w_show ? (ROWS'(1) << r_row_idx) : '0;
         r_col_out <= w_show ? r_mem[r_sel_active][r_row_idx] : '0;
      end
   end

   assign bus.row_oh     = r_row_oh;
   assign bus.col_out    = r_col_out;
   assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_matrix_preset_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_matrix_preset_scanner                                                 |
// | Randomised bench against a frame-arithmetic reference model.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_matrix_preset_scanner;
   localparam int COLS         = 5;
   localparam int ROWS         = 7;
   localparam int SEL_W        = 2;
   localparam int DIV          = 4;
   localparam int BLINK_FRAMES = 2;
   localparam int c_NPAT       = 2 ** SEL_W;
   localparam int c_FRAME      = DIV * ROWS;

   logic clk;
   logic rst_n;

   matrix_preset_scanner_if #(.COLS(COLS), .ROWS(ROWS), .SEL_W(SEL_W)) bus ();

   matrix_preset_scanner #(
      .COLS(COLS), .ROWS(ROWS), .SEL_W(SEL_W), .DIV(DIV), .BLINK_FRAMES(BLINK_FRAMES)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: position in frame derived from a count of enabled cycles.
   int m_ecnt;
   int m_sel;
   int m_bf;
   bit m_blank;
   int m_mem [c_NPAT][ROWS];
   int e_row;
   int e_col;
   int e_fd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ecnt  = 0;
      m_sel   = 0;
      m_bf    = 0;
      m_blank = 1'b0;
      for (int p = 0; p < c_NPAT; p++)
         for (int r = 0; r < ROWS; r++)
            m_mem[p][r] = 0;
      e_row = 0;
      e_col = 0;
      e_fd  = 0;
   endtask

   task automatic model_edge();
      int row;
      row   = (m_ecnt / DIV) % ROWS;
      e_row = (bus.en && !m_blank) ? (1 << row) : 0;
      e_col = (bus.en && !m_blank) ? m_mem[m_sel][row] : 0;
      e_fd  = 0;
      if (bus.en) begin
         if (m_ecnt == c_FRAME - 1) begin
            e_fd  = 1;
            m_sel = int'(bus.sel_in);
            if (bus.blink_en) begin
               m_bf++;
               if (m_bf == BLINK_FRAMES) begin
                  m_bf    = 0;
                  m_blank = !m_blank;
               end
            end
         end
         m_ecnt = (m_ecnt + 1) % c_FRAME;
      end
      if (!bus.blink_en) begin
         m_bf    = 0;
         m_blank = 1'b0;
      end
      if (bus.wr_en && int'(bus.wr_row) < ROWS)
         m_mem[bus.wr_sel][bus.wr_row] = int'(bus.wr_data);
   endtask

   task automatic step_and_check();
      @(posedge clk);
      model_edge();
      #1;
      chk("row_oh", 32'(bus.row_oh), 32'(e_row));
      chk("col_out", 32'(bus.col_out), 32'(e_col));
      chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
   endtask

   task automatic random_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         bus.en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) bus.sel_in = SEL_W'($urandom);
         if ($urandom_range(0, 399) == 0) bus.blink_en = ~bus.blink_en;
         bus.wr_en   = ($urandom_range(0, 4) == 0);
         bus.wr_sel  = SEL_W'($urandom);
         bus.wr_row  = 3'($urandom_range(0, 7));
         bus.wr_data = COLS'($urandom);
         step_and_check();
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.en       = 1'b0;
      bus.sel_in   = '0;
      bus.blink_en = 1'b0;
      bus.wr_en    = 1'b0;
      bus.wr_sel   = '0;
      bus.wr_row   = '0;
      bus.wr_data  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_row_oh", 32'(bus.row_oh), 32'd0);
      chk("reset_col_out", 32'(bus.col_out), 32'd0);
      chk("reset_frame_done", 32'(bus.frame_done), 32'd0);
      rst_n = 1'b1;

      // Plain scan of the cleared memory for two frames.
      bus.en = 1'b1;
      for (int i = 0; i < 2 * c_FRAME + 4; i++) step_and_check();

      // Blinking scan long enough to see several blank/visible phases.
      bus.blink_en = 1'b1;
      bus.wr_en    = 1'b1;
      for (int i = 0; i < 8 * c_FRAME; i++) begin
         bus.wr_sel  = SEL_W'($urandom);
         bus.wr_row  = 3'($urandom_range(0, 7));
         bus.wr_data = COLS'($urandom);
         step_and_check();
      end
      bus.wr_en    = 1'b0;
      bus.blink_en = 1'b0;

      random_cycles(3000);

      // Asynchronous reset asserted between edges must clear outputs at once.
      #2 rst_n = 1'b0;
      #1;
      chk("async_row_oh", 32'(bus.row_oh), 32'd0);
      chk("async_col_out", 32'(bus.col_out), 32'd0);
      chk("async_frame_done", 32'(bus.frame_done), 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;

      bus.en       = 1'b1;
      bus.wr_en    = 1'b0;
      bus.blink_en = 1'b0;
      for (int i = 0; i < c_NPAT * c_FRAME; i++) begin
         bus.sel_in = SEL_W'(i / c_FRAME);
         step_and_check();
      end

      random_cycles(800);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
